// File: rtl/slave_axi_isolate_ctrl.sv
// rtl/slave_axi_isolate_ctrl.sv - isolate-and-reset sequencer for one slave behind the async AXI bridge
// Gates address handshakes, drains in-flight traffic, holds the slave reset, then waits out the bridge synchronisers.
module slave_axi_isolate_ctrl #(
   parameter int MAX_OST    = 8,
   parameter int STABLE_CYC = 4,
   parameter int RST_CYC    = 16,
   parameter int REC_CYC    = 80
) (
   input  logic                             B_CLK,
   input  logic                             B_RSTN,
   input  logic                             REQ_ISO,
   output logic                             ISO_DONE,
   input  logic                             M_WR_ADDR_VALID,
   output logic                             M_WR_ADDR_READY,
   output logic                             B_WR_ADDR_VALID,
   input  logic                             B_WR_ADDR_READY,
   input  logic                             M_RD_ADDR_VALID,
   output logic                             M_RD_ADDR_READY,
   output logic                             B_RD_ADDR_VALID,
   input  logic                             B_RD_ADDR_READY,
   input  logic                             B_WR_BACK_VALID,
   input  logic                             B_WR_BACK_READY,
   input  logic                             B_RD_DATA_VALID,
   input  logic                             B_RD_DATA_READY,
   input  logic                             B_RD_DATA_LAST,
   input  logic [4:0]                       fifo_empty_flag,
   output logic                             SLAVE_RSTN,
   output logic [$clog2(MAX_OST+1)-1:0]     WR_OST,
   output logic [$clog2(MAX_OST+1)-1:0]     RD_OST,
   output logic                             PROTO_ERR,
   output logic [2:0]                       STATE
);
   localparam int CW   = $clog2(MAX_OST + 1);
   localparam int SW   = $clog2(STABLE_CYC + 1);
   localparam int TMAX = (RST_CYC > REC_CYC) ? RST_CYC : REC_CYC;
   localparam int TW   = $clog2(TMAX + 1);
   localparam logic [CW-1:0] OST_MAX     = CW'(MAX_OST);
   localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYC - 1);
   localparam logic [TW-1:0] RST_LAST    = TW'(RST_CYC - 1);
   localparam logic [TW-1:0] REC_LAST    = TW'(REC_CYC - 1);

   typedef enum logic [2:0] {
      S_RUN     = 3'd0,
      S_BLOCK   = 3'd1,
      S_DRAIN   = 3'd2,
      S_RESET   = 3'd3,
      S_HOLD    = 3'd4,
      S_RECOVER = 3'd5
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_wr_ost;
   logic [CW-1:0]   r_rd_ost;
   logic            r_proto_err;
   logic            r_slave_rstn;
   logic            r_iso_done;
   logic [4:0]      r_sync1;
   logic [4:0]      r_sync2;
   logic [SW-1:0]   r_stable;
   logic [TW-1:0]   r_timer;

   logic w_wr_open, w_rd_open;
   logic w_wr_inc, w_wr_dec, w_rd_inc, w_rd_dec;
   logic w_wr_stall, w_rd_stall;
   logic w_all_empty, w_rec_entry;

   assign w_wr_open = (r_state == S_RUN) && (r_wr_ost < OST_MAX);
   assign w_rd_open = (r_state == S_RUN) && (r_rd_ost < OST_MAX);

   assign B_WR_ADDR_VALID = M_WR_ADDR_VALID & w_wr_open;
   assign M_WR_ADDR_READY = B_WR_ADDR_READY & w_wr_open;
   assign B_RD_ADDR_VALID = M_RD_ADDR_VALID & w_rd_open;
   assign M_RD_ADDR_READY = B_RD_ADDR_READY & w_rd_open;

   assign w_wr_inc    = B_WR_ADDR_VALID && B_WR_ADDR_READY;
   assign w_wr_dec    = B_WR_BACK_VALID && B_WR_BACK_READY;
   assign w_rd_inc    = B_RD_ADDR_VALID && B_RD_ADDR_READY;
   assign w_rd_dec    = B_RD_DATA_VALID && B_RD_DATA_READY && B_RD_DATA_LAST;
   assign w_wr_stall  = B_WR_ADDR_VALID && !B_WR_ADDR_READY;
   assign w_rd_stall  = B_RD_ADDR_VALID && !B_RD_ADDR_READY;
   assign w_all_empty = (r_sync2 == 5'b11111);
   assign w_rec_entry = (r_state == S_HOLD) && !REQ_ISO;

   assign WR_OST     = r_wr_ost;
   assign RD_OST     = r_rd_ost;
   assign PROTO_ERR  = r_proto_err;
   assign SLAVE_RSTN = r_slave_rstn;
   assign ISO_DONE   = r_iso_done;
   assign STATE      = r_state;

   // Simultaneous issue and completion cancel; a lone completion at zero is a protocol error.
   always_ff @(posedge B_CLK or negedge B_RSTN) begin
      if (!B_RSTN) begin
         r_wr_ost    <= '0;
         r_rd_ost    <= '0;
         r_proto_err <= 1'b0;
      end else if (w_rec_entry) begin
         r_wr_ost <= '0;
         r_rd_ost <= '0;
      end else begin
         if (w_wr_inc && !w_wr_dec) begin
            r_wr_ost <= r_wr_ost + CW'(1);
         end else if (w_wr_dec && !w_wr_inc) begin
            if (r_wr_ost == '0) r_proto_err <= 1'b1;
            else                r_wr_ost    <= r_wr_ost - CW'(1);
         end
         if (w_rd_inc && !w_rd_dec) begin
            r_rd_ost <= r_rd_ost + CW'(1);
         end else if (w_rd_dec && !w_rd_inc) begin
            if (r_rd_ost == '0) r_proto_err <= 1'b1;
            else                r_rd_ost    <= r_rd_ost - CW'(1);
         end
      end
   end

   always_ff @(posedge B_CLK or negedge B_RSTN) begin
      if (!B_RSTN) begin
         r_state      <= S_RUN;
         r_slave_rstn <= 1'b1;
         r_iso_done   <= 1'b0;
         r_sync1      <= '0;
         r_sync2      <= '0;
         r_stable     <= '0;
         r_timer      <= '0;
      end else begin
         r_sync1 <= fifo_empty_flag;
         r_sync2 <= r_sync1;
         case (r_state)
            S_RUN: begin
               if (REQ_ISO && !w_wr_stall && !w_rd_stall) r_state <= S_BLOCK;
            end
            S_BLOCK: begin
               if (!REQ_ISO) begin
                  r_state <= S_RUN;
               end else if (r_wr_ost == '0 && r_rd_ost == '0) begin
                  r_state  <= S_DRAIN;
                  r_stable <= '0;
               end
            end
            S_DRAIN: begin
               if (!w_all_empty) begin
                  r_stable <= '0;
               end else if (r_stable == STABLE_LAST) begin
                  r_state      <= S_RESET;
                  r_slave_rstn <= 1'b0;
                  r_timer      <= '0;
               end else begin
                  r_stable <= r_stable + SW'(1);
               end
            end
            S_RESET: begin
               if (r_timer == RST_LAST) begin
                  r_state    <= S_HOLD;
                  r_iso_done <= 1'b1;
                  r_timer    <= '0;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            S_HOLD: begin
               if (!REQ_ISO) begin
                  r_state      <= S_RECOVER;
                  r_slave_rstn <= 1'b1;
                  r_iso_done   <= 1'b0;
                  r_timer      <= '0;
               end
            end
            S_RECOVER: begin
               if (r_timer == REC_LAST) begin
                  r_state <= S_RUN;
                  r_timer <= '0;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            default: begin
               r_state      <= S_RUN;
               r_slave_rstn <= 1'b1;
               r_iso_done   <= 1'b0;
               r_timer      <= '0;
            end
         endcase
      end
   end
endmodule
